// File: rtl/shared_bus_arbiter.sv
// Round-robin owner arbitration for a shared tri-state bus, with capture of the
// owner's data word and detection of strobes from requesters that hold no grant.
module shared_bus_arbiter #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         done,
   input  logic [N-1:0]         strobe,
   input  logic [W-1:0]         bus_data,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] owner_id,
   output logic                 busy,
   output logic [W-1:0]         rx_data,
   output logic                 rx_valid,
   output logic                 timeout,
   output logic                 err_contention,
   output logic [1:0]           state_dbg
);

   // Handshake: req is a level held until served; gnt[i] is requester i's
   // driver enable; the owner ends its tenure with a one-cycle done pulse, and
   // strobe marks bus_data valid only while the strobing requester holds gnt.

   localparam int IW = $clog2(N);
   localparam int CW = IW + 1;
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [N-1:0]    gnt_d;
   logic [IW-1:0]   owner_d;
   logic            busy_d;
   logic            timeout_d;
   logic [IW-1:0]   winner;
   logic [CW-1:0]   cand;
   logic            found;
   logic            own_done;
   logic            hold_full;
   logic            release_now;

   assign own_done    = done[owner_id];
   assign hold_full   = (cnt_q == HOLD_MAX);
   assign release_now = own_done || hold_full;
   assign state_dbg   = state_q;

   // First requesting index at or above the RR pointer, wrapping past N-1.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr_q} + CW'(i);
         if (cand >= CW'(N)) cand = cand - CW'(N);
         if (!found && req[cand[IW-1:0]]) begin
            winner = cand[IW-1:0];
            found  = 1'b1;
         end
      end
   end

   // State register plus every registered output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         cnt_q          <= '0;
         gnt            <= '0;
         owner_id       <= '0;
         busy           <= 1'b0;
         timeout        <= 1'b0;
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         err_contention <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         gnt      <= gnt_d;
         owner_id <= owner_d;
         busy     <= busy_d;
         timeout  <= timeout_d;
         rx_valid <= (state_q == GRANT) && strobe[owner_id];
         if ((state_q == GRANT) && strobe[owner_id]) rx_data <= bus_data;
         if (|(strobe & ~gnt)) err_contention <= 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req) state_d = GRANT;
         GRANT:   if (release_now) state_d = TURN;
         TURN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of grant, owner, pointer, hold counter and timeout.
   always_comb begin
      gnt_d     = gnt;
      owner_d   = owner_id;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      busy_d    = (state_d == GRANT);
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d         = '0;
               gnt_d[winner] = 1'b1;
               owner_d       = winner;
               cnt_d         = 8'd1;
            end
         end
         GRANT: begin
            if (release_now) begin
               gnt_d     = '0;
               owner_d   = '0;
               cnt_d     = '0;
               timeout_d = !own_done;
               if (owner_id == IW'(N - 1)) ptr_d = '0;
               else                        ptr_d = owner_id + 1'b1;
            end else if (!hold_full) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         TURN: begin
            gnt_d = '0;
         end
         default: begin
            gnt_d   = '0;
            owner_d = '0;
         end
      endcase
   end

endmodule
